// File: rtl/axi_mem_slave.sv
// ----------------------------------------------------------------------------
// axi_mem_slave
//   Word-addressed memory behind a reduced AXI4 slave interface. Only INCR
//   bursts are supported; the low two address bits are ignored and the word
//   index advances by one per beat, wrapping modulo 2^ADDR_WIDTH bytes.
//   Independent write and read state machines allow one write burst and one
//   read burst to be in flight at the same time.
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   awaddr/awlen/awvalid/awready  write address channel
//   wdata/wstrb/wlast/wvalid/wready write data channel
//   bresp/bvalid/bready           write response channel
//   araddr/arlen/arvalid/arready  read address channel
//   rdata/rresp/rlast/rvalid/rready read data channel
// ----------------------------------------------------------------------------
module axi_mem_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int IW   = ADDR_WIDTH - 2;                       // word index width
    localparam int STRB = DATA_WIDTH / 8;
    localparam int MA   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    // One extra bit so a depth equal to 2^IW still compares correctly.
    localparam logic [IW:0] DEPTH_EXT = (IW+1)'(MEM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Memory starts at zero and is never cleared by reset.
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

    // ---------------- write side state ----------------
    w_state_t        w_state_q, w_state_d;
    logic [IW-1:0]   w_idx_q,   w_idx_d;
    logic [7:0]      w_len_q,   w_len_d;
    logic [7:0]      w_cnt_q,   w_cnt_d;
    logic            w_err_q,   w_err_d;
    logic            awready_q, awready_d;
    logic            wready_q,  wready_d;
    logic            bvalid_q,  bvalid_d;
    logic [1:0]      bresp_q,   bresp_d;

    // ---------------- read side state ----------------
    r_state_t        r_state_q, r_state_d;
    logic [IW-1:0]   r_idx_q,   r_idx_d;
    logic [7:0]      r_len_q,   r_len_d;
    logic [7:0]      r_cnt_q,   r_cnt_d;
    logic            arready_q, arready_d;
    logic            rvalid_q,  rvalid_d;
    logic            rlast_q,   rlast_d;
    logic [1:0]      rresp_q,   rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // ---------------- shared datapath ----------------
    logic                  w_hs;
    logic                  w_in_range;
    logic                  mem_we;
    logic                  w_beat_last;
    logic                  w_beat_err;
    logic [IW-1:0]         r_load_idx;
    logic                  r_in_range;
    logic [DATA_WIDTH-1:0] mem_rd_word;
    logic [DATA_WIDTH-1:0] fwd_word;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [1:0]            beat_resp;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

    assign w_hs       = (w_state_q == W_DATA) && wvalid && wready_q;
    assign w_in_range = ({1'b0, w_idx_q} < DEPTH_EXT);
    assign mem_we     = w_hs && w_in_range;

    // Index of the read beat that will be registered at the next edge:
    // the burst start while idle, otherwise the word after the current beat.
    assign r_load_idx = (r_state_q == R_IDLE) ? araddr[ADDR_WIDTH-1:2]
                                              : r_idx_q + IW'(1);
    assign r_in_range = ({1'b0, r_load_idx} < DEPTH_EXT);
    assign mem_rd_word = mem[r_load_idx[MA-1:0]];

    // A write landing on the same edge that loads a read beat is merged in,
    // so the newly presented beat already sees it.
    assign fwd_hit = mem_we && (w_idx_q == r_load_idx);

    for (genvar gi = 0; gi < STRB; gi++) begin : g_fwd_lane
        assign fwd_word[gi*8 +: 8] = (fwd_hit && wstrb[gi]) ? wdata[gi*8 +: 8]
                                                            : mem_rd_word[gi*8 +: 8];
    end

    assign beat_data = r_in_range ? fwd_word : '0;
    assign beat_resp = r_in_range ? RESP_OKAY : RESP_SLVERR;

    // ---------------- write FSM next state ----------------
    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;

        w_beat_last = (w_cnt_q == w_len_q);
        // Error if this beat is out of range or wlast disagrees with the count.
        w_beat_err  = w_err_q || !w_in_range || (wlast != w_beat_last);

        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;   // also re-arms awready after reset release
                if (awvalid && awready_q) begin
                    w_state_d = W_DATA;
                    w_idx_d   = awaddr[ADDR_WIDTH-1:2];
                    w_len_d   = awlen;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    if (w_beat_last) begin
                        w_state_d = W_RESP;
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = w_beat_err ? RESP_SLVERR : RESP_OKAY;
                        w_err_d   = 1'b0;
                    end else begin
                        w_idx_d = w_idx_q + IW'(1);
                        w_cnt_d = w_cnt_q + 8'd1;
                        w_err_d = w_beat_err;
                    end
                end
            end
            W_RESP: begin
                if (bready && bvalid_q) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                awready_d = 1'b0;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
                bresp_d   = RESP_OKAY;
            end
        endcase
    end

    // ---------------- read FSM next state ----------------
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    r_state_d = R_DATA;
                    r_idx_d   = r_load_idx;
                    r_len_d   = arlen;
                    r_cnt_d   = '0;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = beat_data;
                    rresp_d   = beat_resp;
                    rlast_d   = (arlen == 8'd0);
                end
            end
            R_DATA: begin
                // Beat outputs only change on a handshake, so they hold
                // steady while the master stalls.
                if (rready && rvalid_q) begin
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                        arready_d = 1'b1;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rresp_d   = RESP_OKAY;
                        rdata_d   = '0;
                    end else begin
                        r_idx_d = r_load_idx;
                        r_cnt_d = r_cnt_q + 8'd1;
                        rdata_d = beat_data;
                        rresp_d = beat_resp;
                        rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    // ---------------- memory write port (byte lanes) ----------------
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB; b++) begin
                if (wstrb[b]) begin
                    mem[w_idx_q[MA-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// ----------------------------------------------------------------------------
// tb_axi_mem_slave
//   Directed and randomized bursts against axi_mem_slave, checked against a
//   word-array reference of the memory and the response rules.
// ----------------------------------------------------------------------------
module tb_axi_mem_slave;

    localparam int AW    = 16;
    localparam int DEPTH = 64;
    localparam int TMO   = 50;

    logic        aclk;
    logic        aresetn;
    logic [AW-1:0] awaddr;
    logic [7:0]  awlen;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [AW-1:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    axi_mem_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arlen   (arlen),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference memory and per-burst stimulus / result buffers.
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wd      [256];
    logic [3:0]  ws      [256];
    logic [31:0] rd_got  [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int widx(input int unsigned addr, input int beat);
        return int'(((addr >> 2) + beat) % (1 << (AW - 2)));
    endfunction

    // Write burst of len+1 beats from wd/ws; wlast driven on beat last_at.
    task automatic do_write(input int unsigned addr, input int len, input int last_at);
        int  n;
        int  idx;
        bit  err;
        logic [1:0] exp_resp;
        err     = 0;
        awaddr  = addr[AW-1:0];
        awlen   = len[7:0];
        awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < TMO) begin @(posedge aclk); #1; n++; end
        if (n >= TMO) begin check("aw_timeout", 32'd0, 32'd1); awvalid = 1'b0; return; end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        check("wready_latency", {31'd0, wready}, 32'd1);
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(3) == 0) begin
                wvalid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge aclk);
                #1;
            end
            wdata  = wd[i];
            wstrb  = ws[i];
            wlast  = (i == last_at);
            wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < TMO) begin @(posedge aclk); #1; n++; end
            if (n >= TMO) begin check("w_timeout", 32'd0, 32'd1); wvalid = 1'b0; return; end
            @(posedge aclk); #1;
            idx = widx(addr, i);
            if (idx < DEPTH) begin
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) ref_mem[idx][b*8 +: 8] = wd[i][b*8 +: 8];
            end else begin
                err = 1;
            end
            if ((i == last_at) != (i == len)) err = 1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        exp_resp = err ? 2'b10 : 2'b00;
        check("bvalid_latency", {31'd0, bvalid}, 32'd1);
        check("bresp", {30'd0, bresp}, {30'd0, exp_resp});
        repeat ($urandom_range(0, 2)) begin
            @(posedge aclk); #1;
            check("bvalid_hold", {31'd0, bvalid}, 32'd1);
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        check("bvalid_clear", {31'd0, bvalid}, 32'd0);
        $display("WR addr=%h len=%0d last_at=%0d bresp=%b", addr[AW-1:0], len, last_at, bresp);
    endtask

    // Read burst of len+1 beats; stall<0 picks 0..2 stall cycles per beat.
    task automatic do_read(input int unsigned addr, input int len, input int stall);
        int n;
        int idx;
        int st;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        araddr  = addr[AW-1:0];
        arlen   = len[7:0];
        arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < TMO) begin @(posedge aclk); #1; n++; end
        if (n >= TMO) begin check("ar_timeout", 32'd0, 32'd1); arvalid = 1'b0; return; end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        check("rvalid_latency", {31'd0, rvalid}, 32'd1);
        for (int i = 0; i <= len; i++) begin
            idx   = widx(addr, i);
            exp_d = (idx < DEPTH) ? ref_mem[idx] : 32'd0;
            exp_r = (idx < DEPTH) ? 2'b00 : 2'b10;
            st    = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            for (int s = 0; s < st; s++) begin
                check("rdata_stall", rdata, exp_d);
                check("rlast_stall", {31'd0, rlast}, {31'd0, (i == len)});
                @(posedge aclk); #1;
            end
            rready = 1'b1;
            check("rvalid", {31'd0, rvalid}, 32'd1);
            check("rdata", rdata, exp_d);
            check("rresp", {30'd0, rresp}, {30'd0, exp_r});
            check("rlast", {31'd0, rlast}, {31'd0, (i == len)});
            rd_got[i] = rdata;
            @(posedge aclk); #1;
            rready = 1'b0;
        end
        check("rvalid_clear", {31'd0, rvalid}, 32'd0);
        $display("RD addr=%h len=%0d first=%h", addr[AW-1:0], len, rd_got[0]);
    endtask

    initial begin
        int unsigned a;
        int          l;
        int          la;
        bit          saw_b;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
        aresetn = 1'b0;
        awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;

        // Outputs during reset
        repeat (3) @(posedge aclk);
        #1;
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready",  {31'd0, wready},  32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_bresp",   {30'd0, bresp},   32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rlast",   {31'd0, rlast},   32'd0);
        check("rst_rresp",   {30'd0, rresp},   32'd0);
        check("rst_rdata",   rdata,            32'd0);
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("idle_awready", {31'd0, awready}, 32'd1);
        check("idle_arready", {31'd0, arready}, 32'd1);

        // Basic 4-beat burst
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
        do_write(32'h10, 3, 3);
        do_read(32'h10, 3, 0);
        for (int i = 0; i < 4; i++) check("basic_data", rd_got[i], 32'hA0 + i);

        // Byte-strobe merge
        wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
        do_write(32'h20, 0, 0);
        wd[0] = 32'h1234_5678; ws[0] = 4'b0101;
        do_write(32'h20, 0, 0);
        do_read(32'h20, 0, 0);
        check("strb_merge", rd_got[0], 32'hFF34_FF78);

        // Early wlast, out-of-range, straddling the end of memory
        wd[0] = 32'h1111_0000; wd[1] = 32'h1111_0001; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h30, 1, 0);
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        do_write(DEPTH * 4, 0, 0);
        do_read(DEPTH * 4, 0, 0);
        check("oor_rdata", rd_got[0], 32'd0);
        for (int i = 0; i < 4; i++) begin wd[i] = 32'h5500_0000 + i; ws[i] = 4'hF; end
        do_write(DEPTH * 4 - 8, 3, 3);
        do_read(DEPTH * 4 - 8, 3, -1);

        // Stalled read of 3 beats
        do_read(32'h10, 2, 3);
        for (int i = 0; i < 3; i++) check("stall_order", rd_got[i], 32'hA0 + i);

        // Address wrap at the top of the address space
        wd[0] = 32'h0BAD_0BAD; wd[1] = 32'h600D_600D; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'hFFFC, 1, 1);
        do_read(32'h0, 0, 0);
        check("wrap_word0", rd_got[0], 32'h600D_600D);

        // Concurrent write and read on disjoint words
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        fork
            do_write(32'h80, 3, 3);
            do_read(32'h10, 3, 1);
        join

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            a = $urandom_range(0, DEPTH * 4 + 32);
            l = $urandom_range(0, 7);
            if ($urandom_range(1)) begin
                for (int i = 0; i <= l; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                la = ($urandom_range(7) == 0) ? int'($urandom_range(0, l + 1)) : l;
                do_write(a, l, la);
            end else begin
                do_read(a, l, -1);
            end
        end

        // Reset during beat 2 of a 4-beat write
        awaddr = 16'h40; awlen = 8'd3; awvalid = 1'b1;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        wdata = 32'hC0DE_0001; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        check("rst_mid_wready", {31'd0, wready}, 32'd1);
        @(posedge aclk); #1;
        ref_mem[16] = 32'hC0DE_0001;
        wdata = 32'hC0DE_0002;
        #3;
        aresetn = 1'b0;
        #1;
        check("rst_mid_wready_drop", {31'd0, wready}, 32'd0);
        check("rst_mid_bvalid",      {31'd0, bvalid}, 32'd0);
        check("rst_mid_awready",     {31'd0, awready}, 32'd0);
        wvalid = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        saw_b = 0;
        repeat (10) begin
            @(posedge aclk); #1;
            if (bvalid !== 1'b0) saw_b = 1;
        end
        check("rst_no_bvalid", {31'd0, saw_b}, 32'd0);
        check("rst_rel_awready", {31'd0, awready}, 32'd1);
        do_read(32'h40, 3, 0);
        check("rst_beat1_kept", rd_got[0], 32'hC0DE_0001);
        $display("RST mid-burst write abandoned");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; 32 is the only supported value.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, number of DATA_WIDTH-bit memory words.
REQ-004 SHALL have port aclk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port aresetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port awaddr, input, ADDR_WIDTH, write burst start byte address.
REQ-007 SHALL have port awlen, input, 8, write beats minus 1.
REQ-008 SHALL have port awvalid, input, 1, write address valid.
REQ-009 SHALL have port awready, output, 1, write address ready.
REQ-010 SHALL have port wdata, input, DATA_WIDTH, write data.
REQ-011 SHALL have port wstrb, input, DATA_WIDTH/8, byte-lane enables.
REQ-012 SHALL have port wlast, input, 1, final write beat.
REQ-013 SHALL have port wvalid, input, 1, write data valid.
REQ-014 SHALL have port wready, output, 1, write data ready.
REQ-015 SHALL have port bresp, output, 2, write response (00 OKAY, 10 SLVERR).
REQ-016 SHALL have port bvalid, output, 1, write response valid.
REQ-017 SHALL have port bready, input, 1, write response ready.
REQ-018 SHALL have port araddr, input, ADDR_WIDTH, read burst start byte address.
REQ-019 SHALL have port arlen, input, 8, read beats minus 1.
REQ-020 SHALL have port arvalid, input, 1, read address valid.
REQ-021 SHALL have port arready, output, 1, read address ready.
REQ-022 SHALL have port rdata, output, DATA_WIDTH, read data.
REQ-023 SHALL have port rresp, output, 2, read response per beat.
REQ-024 SHALL have port rlast, output, 1, final read beat.
REQ-025 SHALL have port rvalid, output, 1, read data valid.
REQ-026 SHALL have port rready, input, 1, read data ready.

Function
REQ-027 SHALL implement only INCR bursts: word index = byte address >> 2, low 2 address bits ignored, +1 word per beat, with wrap modulo 2^ADDR_WIDTH.
REQ-028 SHALL run independent write and read state machines, so one write burst and one read burst proceed concurrently, each with one burst outstanding.
REQ-029 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP: W_IDLE drives awready=1 and on awvalid latches address and len, then goes to W_DATA; W_DATA drives wready=1; W_RESP drives bvalid=1 until bready, then returns to W_IDLE.
REQ-030 SHALL write each accepted W beat into only the byte lanes whose wstrb bit is 1, and go to W_RESP after beat awlen+1 is accepted.
REQ-031 SHALL set bresp=10 if wlast is not asserted exactly on beat awlen+1, or if any beat's word index is >= MEM_DEPTH; out-of-range beats SHALL be dropped; otherwise bresp=00.
REQ-032 Read FSM SHALL have states R_IDLE and R_DATA: R_IDLE drives arready=1 and on arvalid latches address and len; R_DATA drives rvalid=1, with rlast=1 on beat arlen+1; after the last beat with rready the FSM returns to R_IDLE.
REQ-033 SHALL hold rdata, rresp and rlast stable while rvalid=1 and rready=0.
REQ-034 SHALL return rdata=0 and rresp=10 for out-of-range beats, and rresp=00 for in-range beats.
REQ-035 Latency SHALL be: AW/AR accepted in the cycle of valid while idle; first wready and rvalid one cycle after the address handshake; bvalid one cycle after the last W handshake.
REQ-036 A write committed at clock edge N SHALL be visible to any read beat presented after edge N; a read beat already presented SHALL keep its old data.

Reset
REQ-037 While aresetn=0, all ready, valid, last and resp outputs and rdata SHALL be 0, and both FSMs SHALL be in IDLE.
REQ-038 Assertion of aresetn mid-burst SHALL abandon the burst immediately, including dropping bvalid and rvalid asynchronously; no partial response SHALL follow release.
REQ-039 Memory contents SHALL be 0 at time zero and SHALL NOT be cleared by aresetn.

Verification
REQ-040 AW addr=0x10 len=3, W 0xA0..0xA3 strb=F, then AR addr=0x10 len=3 -> reads 0xA0..0xA3, rlast on beat 4, bresp=00, rresp=00.
REQ-041 Word 0x20 = 0xFFFFFFFF, then a 1-beat write of 0x12345678 with strb=0101 -> read of 0x20 returns 0xFF34FF78.
REQ-042 Write len=1 with wlast on beat 1 -> bresp=10; write at byte address MEM_DEPTH*4 -> bresp=10, memory unchanged, read there gives rdata=0 and rresp=10.
REQ-043 Read len=2 with rready=0 for 3 cycles per beat -> rdata and rlast stable, 3 beats delivered in order.
REQ-044 aresetn low during beat 2 of a len=3 write -> wready=0 and bvalid=0 immediately; after release awready=1 and no bvalid is seen.
